// File: rtl/date_pkg.sv
// Shared calendar constants, BCD year type and leap/increment helpers for the date path.
package date_pkg;

  localparam logic [3:0] SET_MODE_DEF = 4'b0000;

  localparam logic [4:0] MLEN_31 = 5'd31;
  localparam logic [4:0] MLEN_30 = 5'd30;
  localparam logic [4:0] MLEN_29 = 5'd29;
  localparam logic [4:0] MLEN_28 = 5'd28;

  localparam logic [6:0] FEB = 7'd2;
  localparam logic [6:0] DEC = 7'd12;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {UPD_HOLD, UPD_LOAD, UPD_TICK} upd_e;

  typedef struct packed {
    logic [3:0] d1000;
    logic [3:0] d100;
    logic [3:0] d10;
    logic [3:0] d1;
  } year_t;

  // Divisible-by-4 test on a two-digit BCD pair: the tens parity selects which ones digits qualify.
  function automatic logic leap_bcd(year_t y);
    logic [3:0] hi;
    logic [3:0] lo;
    if (y.d10 == 4'd0 && y.d1 == 4'd0) begin
      hi = y.d1000;
      lo = y.d100;
    end else begin
      hi = y.d10;
      lo = y.d1;
    end
    return (!hi[0] && (lo == 4'd0 || lo == 4'd4 || lo == 4'd8)) ||
           ( hi[0] && (lo == 4'd2 || lo == 4'd6));
  endfunction

  function automatic year_t year_inc(year_t y);
    year_t r;
    r = y;
    if (y.d1 != BCD_MAX) r.d1 = y.d1 + 4'd1;
    else begin
      r.d1 = '0;
      if (y.d10 != BCD_MAX) r.d10 = y.d10 + 4'd1;
      else begin
        r.d10 = '0;
        if (y.d100 != BCD_MAX) r.d100 = y.d100 + 4'd1;
        else begin
          r.d100  = '0;
          r.d1000 = (y.d1000 != BCD_MAX) ? y.d1000 + 4'd1 : '0;
        end
      end
    end
    return r;
  endfunction

  // Binary 0..39 to two BCD digits; the ones digit is the low nibble minus 10*tens mod 16.
  function automatic logic [7:0] bin2bcd(logic [6:0] v);
    logic [3:0] t;
    logic [3:0] sub;
    if (v >= 7'd30) begin
      t = 4'd3; sub = 4'd14;
    end else if (v >= 7'd20) begin
      t = 4'd2; sub = 4'd4;
    end else if (v >= 7'd10) begin
      t = 4'd1; sub = 4'd10;
    end else begin
      t = 4'd0; sub = 4'd0;
    end
    return {t, v[3:0] - sub};
  endfunction

endpackage

// File: rtl/date_counter_if.sv
// Date load/display bus between setter, date_counter and display mux.
// Optional BCD month/day copies exist only when DATE_COUNTER_BCD_OUT_EN is defined.
interface date_counter_if;
  logic [3:0] MODE;
  logic       DAY_TICK;
  logic       LOAD;
  logic [3:0] LD_YEAR1000;
  logic [3:0] LD_YEAR100;
  logic [3:0] LD_YEAR10;
  logic [3:0] LD_YEAR1;
  logic [6:0] LD_MONTH;
  logic [6:0] LD_DAY;
  logic [3:0] YEAR1000;
  logic [3:0] YEAR100;
  logic [3:0] YEAR10;
  logic [3:0] YEAR1;
  logic [6:0] MONTH;
  logic [6:0] DAY;
  logic       LEAP;
  logic       CLAMPED;
`ifdef DATE_COUNTER_BCD_OUT_EN
  logic [3:0] MONTH10;
  logic [3:0] MONTH1;
  logic [3:0] DAY10;
  logic [3:0] DAY1;
`endif

  modport master (
    output MODE, DAY_TICK, LOAD, LD_YEAR1000, LD_YEAR100, LD_YEAR10, LD_YEAR1,
           LD_MONTH, LD_DAY,
    input  YEAR1000, YEAR100, YEAR10, YEAR1, MONTH, DAY, LEAP, CLAMPED
`ifdef DATE_COUNTER_BCD_OUT_EN
    , input MONTH10, MONTH1, DAY10, DAY1
`endif
  );

  modport slave (
    input  MODE, DAY_TICK, LOAD, LD_YEAR1000, LD_YEAR100, LD_YEAR10, LD_YEAR1,
           LD_MONTH, LD_DAY,
    output YEAR1000, YEAR100, YEAR10, YEAR1, MONTH, DAY, LEAP, CLAMPED
`ifdef DATE_COUNTER_BCD_OUT_EN
    , output MONTH10, MONTH1, DAY10, DAY1
`endif
  );
endinterface

// File: rtl/date_counter_month_len.sv
// Combinational month length lookup; months outside 1..12 report 31.
module month_len
  import date_pkg::*;
(
  input  logic [6:0] month_i,
  input  logic       leap_i,
  output logic [4:0] length_o
);
  always_comb begin
    length_o = MLEN_31;
    case (month_i)
      7'd4, 7'd6, 7'd9, 7'd11: length_o = MLEN_30;
      FEB:                     length_o = leap_i ? MLEN_29 : MLEN_28;
      default:                 length_o = MLEN_31;
    endcase
  end
endmodule

// File: rtl/date_counter.sv
// Running calendar: normalising LOAD, day-tick advance with BCD year ripple and leap tracking.
// Define DATE_COUNTER_BCD_OUT_EN for registered BCD month/day outputs.
module date_counter
  import date_pkg::*;
#(
  parameter logic [3:0]  SET_MODE = SET_MODE_DEF,
  parameter logic [15:0] RST_YEAR = 16'h2020
) (
  input logic           CLK,
  input logic           RESET,
  date_counter_if.slave bus
);
  year_t      year_q, year_d, ld_year;
  logic [6:0] month_q, month_d, ld_month;
  logic [6:0] day_q, day_d, ld_day;
  logic       leap_q, leap_d, ld_leap;
  logic       clamped_q, clamped_d;
  logic [4:0] ld_mlen, tk_mlen;
  upd_e       upd;

  month_len u_len_ld (.month_i(ld_month), .leap_i(ld_leap), .length_o(ld_mlen));
  month_len u_len_tk (.month_i(month_q),  .leap_i(leap_q),  .length_o(tk_mlen));

  always_comb begin
    ld_year.d1000 = (bus.LD_YEAR1000 > BCD_MAX) ? BCD_MAX : bus.LD_YEAR1000;
    ld_year.d100  = (bus.LD_YEAR100  > BCD_MAX) ? BCD_MAX : bus.LD_YEAR100;
    ld_year.d10   = (bus.LD_YEAR10   > BCD_MAX) ? BCD_MAX : bus.LD_YEAR10;
    ld_year.d1    = (bus.LD_YEAR1    > BCD_MAX) ? BCD_MAX : bus.LD_YEAR1;
    ld_month = (bus.LD_MONTH == 7'd0) ? 7'd1 :
               (bus.LD_MONTH > DEC)   ? DEC  : bus.LD_MONTH;
    ld_leap  = leap_bcd(ld_year);
    ld_day   = (bus.LD_DAY == 7'd0)            ? 7'd1           :
               (bus.LD_DAY > {2'b00, ld_mlen}) ? {2'b00, ld_mlen} : bus.LD_DAY;
  end

  always_comb begin
    upd = UPD_HOLD;
    if (bus.LOAD)                                upd = UPD_LOAD;
    else if (bus.DAY_TICK && bus.MODE != SET_MODE) upd = UPD_TICK;
  end

  always_comb begin
    year_d    = year_q;
    month_d   = month_q;
    day_d     = day_q;
    clamped_d = 1'b0;
    case (upd)
      UPD_LOAD: begin
        year_d    = ld_year;
        month_d   = ld_month;
        day_d     = ld_day;
        clamped_d = (ld_year  != {bus.LD_YEAR1000, bus.LD_YEAR100, bus.LD_YEAR10, bus.LD_YEAR1}) ||
                    (ld_month != bus.LD_MONTH) || (ld_day != bus.LD_DAY);
      end
      UPD_TICK: begin
        if (day_q < {2'b00, tk_mlen}) day_d = day_q + 7'd1;
        else begin
          day_d = 7'd1;
          if (month_q < DEC) month_d = month_q + 7'd1;
          else begin
            month_d = 7'd1;
            year_d  = year_inc(year_q);
          end
        end
      end
      default: ;
    endcase
    leap_d = leap_bcd(year_d);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      year_q    <= year_t'(RST_YEAR);
      month_q   <= 7'd1;
      day_q     <= 7'd1;
      leap_q    <= leap_bcd(year_t'(RST_YEAR));
      clamped_q <= 1'b0;
    end else begin
      year_q    <= year_d;
      month_q   <= month_d;
      day_q     <= day_d;
      leap_q    <= leap_d;
      clamped_q <= clamped_d;
    end
  end

  assign bus.YEAR1000 = year_q.d1000;
  assign bus.YEAR100  = year_q.d100;
  assign bus.YEAR10   = year_q.d10;
  assign bus.YEAR1    = year_q.d1;
  assign bus.MONTH    = month_q;
  assign bus.DAY      = day_q;
  assign bus.LEAP     = leap_q;
  assign bus.CLAMPED  = clamped_q;

`ifdef DATE_COUNTER_BCD_OUT_EN
  logic [7:0] mbcd_q, dbcd_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mbcd_q <= 8'h01;
      dbcd_q <= 8'h01;
    end else begin
      mbcd_q <= bin2bcd(month_d);
      dbcd_q <= bin2bcd(day_d);
    end
  end

  assign bus.MONTH10 = mbcd_q[7:4];
  assign bus.MONTH1  = mbcd_q[3:0];
  assign bus.DAY10   = dbcd_q[7:4];
  assign bus.DAY1    = dbcd_q[3:0];
`endif
endmodule

// File: tb/tb_date_counter.sv
// Directed bench for date_counter: reset, leap rollover, year ripple, clamping, priority.
module tb_date_counter;
  logic clk = 1'b0;
  logic rst;
  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  date_counter_if dif ();

  date_counter #(.SET_MODE(4'b0000), .RST_YEAR(16'h2020)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (dif)
  );

  // {year BCD, month, day}
  function automatic logic [29:0] cur();
    return {dif.YEAR1000, dif.YEAR100, dif.YEAR10, dif.YEAR1, dif.MONTH, dif.DAY};
  endfunction

  task automatic do_load(input logic [15:0] y, input logic [6:0] m, input logic [6:0] d,
                         input logic tick);
    @(negedge clk);
    dif.LOAD = 1'b1; dif.DAY_TICK = tick;
    dif.LD_YEAR1000 = y[15:12]; dif.LD_YEAR100 = y[11:8];
    dif.LD_YEAR10 = y[7:4]; dif.LD_YEAR1 = y[3:0];
    dif.LD_MONTH = m; dif.LD_DAY = d;
    @(posedge clk); #1;
    dif.LOAD = 1'b0; dif.DAY_TICK = 1'b0;
  endtask

  task automatic do_tick(input int unsigned n);
    @(negedge clk);
    dif.DAY_TICK = 1'b1;
    repeat (n) @(posedge clk);
    #1 dif.DAY_TICK = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; dif.DAY_TICK = 1'b1; dif.LOAD = 1'b0; dif.MODE = 4'b0001;
    dif.LD_YEAR1000 = '0; dif.LD_YEAR100 = '0; dif.LD_YEAR10 = '0; dif.LD_YEAR1 = '0;
    dif.LD_MONTH = '0; dif.LD_DAY = '0;
    repeat (2) @(posedge clk); #1;
    checks++; if (cur() !== {16'h2020, 7'd1, 7'd1}) begin errors++; $display("FAIL reset_date got=%h exp=%h", cur(), {16'h2020, 7'd1, 7'd1}); end
    checks++; if (dif.LEAP !== 1'b1) begin errors++; $display("FAIL reset_leap got=%b exp=1", dif.LEAP); end
    checks++; if (dif.CLAMPED !== 1'b0) begin errors++; $display("FAIL reset_clamped got=%b exp=0", dif.CLAMPED); end
    rst = 1'b0; dif.DAY_TICK = 1'b0;
  endtask

  task automatic test_leap_rollover();
    do_load(16'h2020, 7'd2, 7'd28, 1'b0);
    checks++; if (dif.CLAMPED !== 1'b0) begin errors++; $display("FAIL load2020_clamped got=%b exp=0", dif.CLAMPED); end
    do_tick(1);
    checks++; if (cur() !== {16'h2020, 7'd2, 7'd29}) begin errors++; $display("FAIL leap_feb29 got=%h exp=%h", cur(), {16'h2020, 7'd2, 7'd29}); end
    do_tick(1);
    checks++; if (cur() !== {16'h2020, 7'd3, 7'd1}) begin errors++; $display("FAIL leap_mar1 got=%h exp=%h", cur(), {16'h2020, 7'd3, 7'd1}); end
    do_load(16'h2019, 7'd2, 7'd28, 1'b0);
    checks++; if (dif.LEAP !== 1'b0) begin errors++; $display("FAIL leap2019 got=%b exp=0", dif.LEAP); end
    do_tick(1);
    checks++; if (cur() !== {16'h2019, 7'd3, 7'd1}) begin errors++; $display("FAIL nonleap_mar1 got=%h exp=%h", cur(), {16'h2019, 7'd3, 7'd1}); end
    do_load(16'h1900, 7'd2, 7'd28, 1'b0);
    do_tick(1);
    checks++; if (cur() !== {16'h1900, 7'd3, 7'd1}) begin errors++; $display("FAIL y1900_mar1 got=%h exp=%h", cur(), {16'h1900, 7'd3, 7'd1}); end
    checks++; if (dif.LEAP !== 1'b0) begin errors++; $display("FAIL y1900_leap got=%b exp=0", dif.LEAP); end
    do_load(16'h2000, 7'd2, 7'd28, 1'b0);
    do_tick(1);
    checks++; if (cur() !== {16'h2000, 7'd2, 7'd29}) begin errors++; $display("FAIL y2000_feb29 got=%h exp=%h", cur(), {16'h2000, 7'd2, 7'd29}); end
    checks++; if (dif.LEAP !== 1'b1) begin errors++; $display("FAIL y2000_leap got=%b exp=1", dif.LEAP); end
  endtask

  task automatic test_year_ripple();
    do_load(16'h1999, 7'd12, 7'd31, 1'b0);
    checks++; if (dif.LEAP !== 1'b0) begin errors++; $display("FAIL y1999_leap got=%b exp=0", dif.LEAP); end
    do_tick(1);
    checks++; if (cur() !== {16'h2000, 7'd1, 7'd1}) begin errors++; $display("FAIL ripple_2000 got=%h exp=%h", cur(), {16'h2000, 7'd1, 7'd1}); end
    checks++; if (dif.LEAP !== 1'b1) begin errors++; $display("FAIL ripple_2000_leap got=%b exp=1", dif.LEAP); end
    do_load(16'h9999, 7'd12, 7'd31, 1'b0);
    do_tick(1);
    checks++; if (cur() !== {16'h0000, 7'd1, 7'd1}) begin errors++; $display("FAIL wrap_0000 got=%h exp=%h", cur(), {16'h0000, 7'd1, 7'd1}); end
    checks++; if (dif.LEAP !== 1'b1) begin errors++; $display("FAIL wrap_0000_leap got=%b exp=1", dif.LEAP); end
  endtask

  task automatic test_clamp();
    do_load(16'h2021, 7'd0, 7'd0, 1'b0);
    checks++; if (cur() !== {16'h2021, 7'd1, 7'd1}) begin errors++; $display("FAIL clamp_zero got=%h exp=%h", cur(), {16'h2021, 7'd1, 7'd1}); end
    checks++; if (dif.CLAMPED !== 1'b1) begin errors++; $display("FAIL clamp_zero_flag got=%b exp=1", dif.CLAMPED); end
    @(posedge clk); #1;
    checks++; if (dif.CLAMPED !== 1'b0) begin errors++; $display("FAIL clamp_pulse_end got=%b exp=0", dif.CLAMPED); end
    do_load(16'h2021, 7'd2, 7'd30, 1'b0);
    checks++; if (cur() !== {16'h2021, 7'd2, 7'd28}) begin errors++; $display("FAIL clamp_feb30 got=%h exp=%h", cur(), {16'h2021, 7'd2, 7'd28}); end
    checks++; if (dif.CLAMPED !== 1'b1) begin errors++; $display("FAIL clamp_feb30_flag got=%b exp=1", dif.CLAMPED); end
    do_load(16'h2021, 7'd4, 7'd31, 1'b0);
    checks++; if (cur() !== {16'h2021, 7'd4, 7'd30}) begin errors++; $display("FAIL clamp_apr31 got=%h exp=%h", cur(), {16'h2021, 7'd4, 7'd30}); end
    do_load(16'h2021, 7'd3, 7'd15, 1'b0);
    checks++; if (cur() !== {16'h2021, 7'd3, 7'd15}) begin errors++; $display("FAIL noclamp_date got=%h exp=%h", cur(), {16'h2021, 7'd3, 7'd15}); end
    checks++; if (dif.CLAMPED !== 1'b0) begin errors++; $display("FAIL noclamp_flag got=%b exp=0", dif.CLAMPED); end
    do_load(16'h2A2F, 7'd13, 7'd40, 1'b0);
    checks++; if (cur() !== {16'h2929, 7'd12, 7'd31}) begin errors++; $display("FAIL clamp_digits got=%h exp=%h", cur(), {16'h2929, 7'd12, 7'd31}); end
    checks++; if (dif.CLAMPED !== 1'b1) begin errors++; $display("FAIL clamp_digits_flag got=%b exp=1", dif.CLAMPED); end
  endtask

  task automatic test_priority();
    do_load(16'h2020, 7'd5, 7'd5, 1'b1);
    checks++; if (cur() !== {16'h2020, 7'd5, 7'd5}) begin errors++; $display("FAIL load_over_tick got=%h exp=%h", cur(), {16'h2020, 7'd5, 7'd5}); end
    dif.MODE = 4'b0000;
    do_tick(3);
    checks++; if (cur() !== {16'h2020, 7'd5, 7'd5}) begin errors++; $display("FAIL setmode_hold got=%h exp=%h", cur(), {16'h2020, 7'd5, 7'd5}); end
    dif.MODE = 4'b0001;
    do_tick(3);
    checks++; if (cur() !== {16'h2020, 7'd5, 7'd8}) begin errors++; $display("FAIL back_to_back got=%h exp=%h", cur(), {16'h2020, 7'd5, 7'd8}); end
    checks++; if (dif.CLAMPED !== 1'b0) begin errors++; $display("FAIL tick_clamped got=%b exp=0", dif.CLAMPED); end
    @(negedge clk);
    rst = 1'b1; dif.LOAD = 1'b1; dif.DAY_TICK = 1'b1;
    dif.LD_YEAR1000 = 4'd2; dif.LD_YEAR100 = 4'd0; dif.LD_YEAR10 = 4'd2; dif.LD_YEAR1 = 4'd1;
    dif.LD_MONTH = 7'd3; dif.LD_DAY = 7'd0;
    @(posedge clk); #1;
    rst = 1'b0; dif.LOAD = 1'b0; dif.DAY_TICK = 1'b0;
    checks++; if (cur() !== {16'h2020, 7'd1, 7'd1}) begin errors++; $display("FAIL reset_over_load got=%h exp=%h", cur(), {16'h2020, 7'd1, 7'd1}); end
    checks++; if (dif.CLAMPED !== 1'b0) begin errors++; $display("FAIL reset_over_load_flag got=%b exp=0", dif.CLAMPED); end
  endtask

`ifdef DATE_COUNTER_BCD_OUT_EN
  task automatic test_bcd_out();
    do_load(16'h2020, 7'd11, 7'd29, 1'b0);
    checks++; if ({dif.MONTH10, dif.MONTH1, dif.DAY10, dif.DAY1} !== 16'h1129) begin errors++; $display("FAIL bcd_load got=%h exp=1129", {dif.MONTH10, dif.MONTH1, dif.DAY10, dif.DAY1}); end
    do_tick(1);
    checks++; if ({dif.MONTH10, dif.MONTH1, dif.DAY10, dif.DAY1} !== 16'h1130) begin errors++; $display("FAIL bcd_tick got=%h exp=1130", {dif.MONTH10, dif.MONTH1, dif.DAY10, dif.DAY1}); end
  endtask
`endif

  initial begin
    test_reset();
    test_leap_rollover();
    test_year_ripple();
    test_clamp();
    test_priority();
`ifdef DATE_COUNTER_BCD_OUT_EN
    test_bcd_out();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/date_counter.md
Name: date_counter

Overview:
- Calendar keeper that consumes the date produced by the date-set mode and owns the running date.
- Takes the set values on a LOAD pulse and normalises invalid entries, such as day 0 or Feb 30.
- Advances the date by one day on each DAY_TICK pulse from the time-of-day counter, handling month, year and leap-year rollover.
- Outputs drive the display mux in the same format the setter uses: BCD year digits, binary month and day.

Parameters:
- SET_MODE, 4'b0000, MODE value for date-set mode; DAY_TICK is ignored while MODE equals it.
- RST_YEAR, 16'h2020, reset year as four BCD digits, thousands digit in [15:12].

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- MODE  in  4  current UI mode.
- DAY_TICK  in  1  one-cycle pulse at midnight rollover.
- LOAD  in  1  one-cycle pulse: capture the LD_* inputs.
- LD_YEAR1000, LD_YEAR100, LD_YEAR10, LD_YEAR1  in  4 each  BCD year digits from the setter.
- LD_MONTH  in  7  binary month from the setter, may be out of range.
- LD_DAY  in  7  binary day from the setter, may be out of range.
- YEAR1000, YEAR100, YEAR10, YEAR1  out  4 each  running year, BCD.
- MONTH  out  7  running month, binary 1..12.
- DAY  out  7  running day, binary 1..month length.
- LEAP  out  1  registered leap flag for the current YEAR.
- CLAMPED  out  1  one-cycle pulse: the last LOAD was normalised.

Behaviour:
- Reset (RESET=1 at posedge):
  - Year = RST_YEAR, MONTH=1, DAY=1.
  - LEAP = leap(RST_YEAR); with the default this is 1.
  - CLAMPED=0.
  - Reset overrides LOAD and DAY_TICK in the same cycle.
- Leap rule on BCD digits, no binary conversion:
  - Year10/1 = 00: leap iff the century (YEAR1000, YEAR100) is divisible by 4. That is, YEAR1000 even and YEAR100 in {0,4,8}, or YEAR1000 odd and YEAR100 in {2,6}.
  - Otherwise: leap iff YEAR10 even and YEAR1 in {0,4,8}, or YEAR10 odd and YEAR1 in {2,6}.
  - LEAP is recomputed from the next-state year every update, so it is valid in the same cycle as the year outputs.
- Month length mlen(m, leap): 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; 29/28 for 2.
- LOAD (priority over DAY_TICK in the same cycle; that tick is dropped, not deferred):
  - Month: m' = 1 if LD_MONTH=0; 12 if LD_MONTH>12; else LD_MONTH.
  - Year digits >9: each replaced by 9.
  - Leap is computed from the clamped year.
  - Day: d' = 1 if LD_DAY=0; mlen(m', leap) if LD_DAY exceeds it; else LD_DAY.
  - All outputs update 1 cycle after LOAD.
  - CLAMPED=1 for that one cycle iff any field changed; else 0.
  - LOAD is accepted in any MODE.
- DAY_TICK (no LOAD, MODE != SET_MODE):
  - DAY < mlen: DAY+1.
  - DAY = mlen: DAY=1, then MONTH+1, or MONTH=1 with a year increment if MONTH=12.
  - Year increment is BCD ripple: YEAR1 9→0 carries into YEAR10, and so on upward.
  - 9999 wraps to 0000; year 0000 is leap.
  - Latency is 1 cycle; a tick every cycle must advance every cycle.
- MODE = SET_MODE: DAY_TICK is ignored and all outputs hold.
- CLAMPED is 0 in every cycle without a LOAD.

Optional Feature:
- Macro: DATE_COUNTER_BCD_OUT_EN.
- When defined:
  - Adds outputs MONTH10, MONTH1, DAY10, DAY1 (4 bits each).
  - These are registered BCD copies of MONTH and DAY, updated in the same cycle as the binary outputs.
  - Reset values: 0,1,0,1.
- When undefined: the ports and registers are absent; everything else is identical.

Decomposition:
- Package date_pkg holds:
  - SET_MODE default.
  - Month-length constants (31/30/29/28).
  - Month encodings FEB=2, DEC=12.
  - BCD digit max 9.
- One sub-module month_len:
  - Combinational; inputs month[6:0] and leap; output length[4:0].
  - Instantiated twice: for the LOAD clamp path and for the tick path.
  - Reusable by the setter later.

Test Plan:
- Reset: RESET=1 for 2 cycles → 2020/1/1, LEAP=1, CLAMPED=0; DAY_TICK held high in the same cycles is ignored.
- Leap rollover: load 2020/2/28, 2 ticks → 2/29 then 3/1. Load 2019/2/28, 1 tick → 3/1. Load 1900/2/28, 1 tick → 3/1, LEAP=0. Load 2000/2/28, 1 tick → 2/29, LEAP=1.
- Year ripple: load 1999/12/31, tick → 2000/1/1. Load 9999/12/31, tick → 0000/1/1, LEAP=1.
- Clamping: load month 0 day 0 → 1/1, CLAMPED=1. Load 2021/2/30 → 2/28, CLAMPED=1. Load 2021/4/31 → 4/30. Load 2021/3/15 → unchanged, CLAMPED=0.
- Priority: LOAD and DAY_TICK asserted together with 2020/5/5 → 5/5, not 5/6. MODE=SET_MODE with 3 ticks → date unchanged. MODE=4'b0001 with 3 ticks → advances 3 days.
- DATE_COUNTER_BCD_OUT_EN build: load 2020/11/29 → MONTH10=1, MONTH1=1, DAY10=2, DAY1=9; tick → 11/30, DAY10=3, DAY1=0.
